// File: rtl/fifo_if.sv
// Signal bundle between a synchronous FIFO and its user.
// The dut modport is the FIFO's view; the user modport is the mirror image.
interface fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport dut (
    input  wr_en, wr_data, rd_en,
    output rd_data, full, empty, count, overflow, underflow
  );

  modport user (
    output wr_en, wr_data, rd_en,
    input  rd_data, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo.sv
// Synchronous FIFO with registered read data and one-cycle overflow/underflow pulses.
// Pointers carry an extra wrap bit so full and empty are told apart without a counter.
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic  clk,
  input logic  rstn,
  fifo_if.dut  syn_fifo_if
);
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  ovf_q, unf_q;
  logic                  full, empty, wr_acc, rd_acc;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                  (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  assign wr_acc = syn_fifo_if.wr_en && !full;
  assign rd_acc = syn_fifo_if.rd_en && !empty;

  // Storage is deliberately left out of reset; the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[ADDR_WIDTH-1:0]] <= syn_fifo_if.wr_data;
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_q   <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        rd_q   <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
      ovf_q <= syn_fifo_if.wr_en && full;
      unf_q <= syn_fifo_if.rd_en && empty;
    end
  end

  assign syn_fifo_if.rd_data   = rd_q;
  assign syn_fifo_if.full      = full;
  assign syn_fifo_if.empty     = empty;
  assign syn_fifo_if.count     = wr_ptr - rd_ptr;
  assign syn_fifo_if.overflow  = ovf_q;
  assign syn_fifo_if.underflow = unf_q;
endmodule

// File: tb/tb_fifo.sv
// Directed and random traffic against fifo, checked by a queue-based reference.
module tb_fifo;
  localparam int DW = 8;
  localparam int DEPTH = 32;
  localparam int AW = 5;

  logic clk;
  logic rstn;
  fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) sif ();

  fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .syn_fifo_if (sif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_assert = 0;
  int n_fail   = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] exp_rd;
  logic          exp_ovf, exp_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_state(input string tag);
    logic [AW:0] ecnt;
    ecnt = AW'(0) + (AW+1)'(sb.size());
    chk({tag, ".count"},     32'(sif.count), 32'(ecnt));
    chk({tag, ".empty"},     32'(sif.empty), 32'(sb.size() == 0));
    chk({tag, ".full"},      32'(sif.full),  32'(sb.size() == DEPTH));
    chk({tag, ".rd_data"},   32'(sif.rd_data), 32'(exp_rd));
    chk({tag, ".overflow"},  32'(sif.overflow), 32'(exp_ovf));
    chk({tag, ".underflow"}, 32'(sif.underflow), 32'(exp_unf));
  endtask

  // One clock: drive after the falling edge, update the model, check 1ns after the rising edge.
  task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re, input string tag);
    logic wacc, racc;
    @(negedge clk);
    sif.wr_en = we; sif.wr_data = wd; sif.rd_en = re;
    wacc = we && (sb.size() < DEPTH);
    racc = re && (sb.size() > 0);
    if (racc) exp_rd = sb.pop_front();
    if (wacc) sb.push_back(wd);
    exp_ovf = we && !wacc;
    exp_unf = re && !racc;
    @(posedge clk);
    #1;
    chk_state(tag);
  endtask

  task automatic model_reset();
    sb.delete();
    exp_rd = '0; exp_ovf = 1'b0; exp_unf = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    sif.wr_en = 1'b0; sif.rd_en = 1'b0; sif.wr_data = '0;
    rstn = 1'b1;
    model_reset();
    #1;
    chk_state(tag);
    @(negedge clk);
    rstn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    sif.wr_en = 1'b0; sif.rd_en = 1'b0; sif.wr_data = '0;
    rstn = 1'b1;
    model_reset();
    #3;
    chk_state("reset0");
    @(negedge clk);
    rstn = 1'b0;

    // Two writes then two reads
    cycle(1'b1, 8'd1, 1'b0, "wr1");
    cycle(1'b1, 8'd2, 1'b0, "wr2");
    cycle(1'b0, 8'd0, 1'b1, "rd1");
    cycle(1'b0, 8'd0, 1'b1, "rd2");
    cycle(1'b0, 8'd0, 1'b0, "idle");

    // Simultaneous read/write starting from empty
    do_reset("reset1");
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'd3, 1'b1, "rw_empty");

    // Fill past full, then drain past empty
    do_reset("reset2");
    for (int i = 0; i < 37; i++) cycle(1'b1, DW'(i % 16), 1'b0, "fill");
    cycle(1'b1, 8'hEE, 1'b1, "rw_full");
    cycle(1'b1, 8'd15, 1'b0, "refill");
    for (int i = 0; i < 40; i++) cycle(1'b0, 8'd0, 1'b1, "drain");
    cycle(1'b0, 8'd0, 1'b0, "hold");

    // Asynchronous reset with 10 words stored
    do_reset("reset3");
    for (int i = 0; i < 11; i++) cycle(1'b1, DW'(8'hA0 + i), 1'b0, "pre_ar");
    cycle(1'b0, 8'd0, 1'b1, "pre_ar_rd");
    @(negedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
    #1;
    chk_state("async_rst");
    @(negedge clk);
    rstn = 1'b0;

    // Random mixed traffic
    for (int i = 0; i < 300; i++)
      cycle(1'(($urandom_range(0, 99)) < 55), DW'($urandom), 1'($urandom_range(0, 1)), "rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each stored word.
REQ-002 Parameter DEPTH, default 32: number of storage entries; a power of two, at least 2.
REQ-003 Parameter ADDR_WIDTH, default 5: log2(DEPTH), the width of the read and write indices.
REQ-004 clk  input  1  the single clock; every register is updated on its rising edge.
REQ-005 rstn  input  1  reset; asynchronous, active-high, so asserted when 1.
REQ-006 syn_fifo_if  interface port  -  bundle of type fifo_if carrying REQ-007..REQ-015.
REQ-007 wr_en  input  1  write request, sampled at the rising edge of clk.
REQ-008 wr_data  input  DATA_WIDTH  word to write.
REQ-009 rd_en  input  1  read request, sampled at the rising edge of clk.
REQ-010 rd_data  output  DATA_WIDTH  registered word from the most recent accepted read.
REQ-011 full  output  1  high when the FIFO holds DEPTH words.
REQ-012 empty  output  1  high when the FIFO holds 0 words.
REQ-013 count  output  ADDR_WIDTH+1  number of words currently stored, from 0 to DEPTH.
REQ-014 overflow  output  1  one-cycle pulse: a write was rejected.
REQ-015 underflow  output  1  one-cycle pulse: a read was rejected.

Function
REQ-016 Storage is a DEPTH x DATA_WIDTH register array.
REQ-017 Write and read pointers are ADDR_WIDTH+1 bits wide: the low bits index the array and the MSB is the wrap bit.
REQ-018 A write is accepted at a rising clk edge when wr_en=1 and full=0: mem[wr_ptr] <= wr_data and wr_ptr increments.
REQ-019 A read is accepted at a rising clk edge when rd_en=1 and empty=0: rd_data <= mem[rd_ptr] and rd_ptr increments.
REQ-020 Read latency is one cycle: rd_data is valid right after the accepting edge.
REQ-021 rd_data holds its value when no read is accepted.
REQ-022 Data leaves the FIFO in strict write order.
REQ-023 Pointers wrap from DEPTH-1 to 0 in the low bits and toggle the wrap bit.
REQ-024 empty = (wr_ptr == rd_ptr).
REQ-025 full = (low bits equal) AND (wrap bits differ).
REQ-026 full, empty and count are combinational from registered pointers, so they reflect the state after each edge.
REQ-027 Simultaneous wr_en and rd_en while 0 < count < DEPTH: both are accepted and count is unchanged.
REQ-028 Simultaneous wr_en and rd_en while empty: only the write is accepted, underflow pulses, count becomes 1.
REQ-029 Simultaneous wr_en and rd_en while full: only the read is accepted, overflow pulses, count becomes DEPTH-1.
REQ-030 A rejected write (wr_en=1 while full=1) leaves memory and pointers unchanged and sets overflow=1 for the following cycle.
REQ-031 A rejected read (rd_en=1 while empty=1) leaves pointers and rd_data unchanged and sets underflow=1 for the following cycle.
REQ-032 overflow and underflow are registered and clear to 0 on the next edge that has no rejection.

Reset
REQ-033 While rstn=1, independent of clk: wr_ptr=0, rd_ptr=0, rd_data=0, overflow=0, underflow=0.
REQ-034 While rstn=1 the outputs are therefore empty=1, full=0, count=0.
REQ-035 Memory contents are not reset and are unobservable until written.
REQ-036 Asserting rstn mid-operation discards all stored words immediately.
REQ-037 The first accepted operation occurs at the first rising clk edge after rstn deasserts.

Verification
REQ-038 Reset, then write 1 and 2 on consecutive cycles -> count=2, empty=0.
REQ-039 Continue from REQ-038 and read twice -> rd_data=1, then rd_data=2; then empty=1, count=0.
REQ-040 Reset, then hold wr_en=rd_en=1 for 4 cycles with wr_data=3 -> first edge write only with underflow=1; next three edges count stays 1; rd_data=3.
REQ-041 Reset, then write 37 incrementing values (4-bit wrapping) -> count reaches 32, full=1 after the 32nd write, overflow=1 for writes 33-37, stored data unchanged.
REQ-042 Continue from REQ-041 and read 40 times -> the first 32 written values are returned in order, empty=1 after the 32nd read, underflow pulses for reads 33-40, rd_data holds the 32nd value.
REQ-043 Assert rstn while count=10 -> count=0, empty=1, rd_data=0 immediately, without waiting for a clk edge.
